// File: rtl/thermometer_serial_decoder.sv
// Serial-in thermometer decoder: W-bit codeword LSB first -> K-bit value + bubble flag.
// THERMO_BUBBLE_CORRECT_EN: q = total ones count; otherwise q = leading-ones count.
module thermometer_serial_decoder #(
  parameter int K = 7,
  parameter int W = 2**K-1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         din,
  input  logic         din_valid,
  output logic [K-1:0] q,
  output logic         q_valid,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t       state, state_nx;
  logic [K-1:0] bitcnt, onescnt, leadcnt;
  logic         seen_zero, bubble;
  logic         take, last;
  logic [K-1:0] ones_nx, lead_nx, q_sel;
  logic         bubble_nx;

  assign take = (state == SHIFT) && din_valid;
  assign last = take && (bitcnt == K'(W-1));
  assign busy = (state == SHIFT);

  // Counter values including the bit being accepted, so the final bit lands in q directly.
  assign ones_nx   = onescnt + K'(din);
  assign lead_nx   = leadcnt + K'(din & ~seen_zero);
  assign bubble_nx = bubble | (din & seen_zero);

`ifdef THERMO_BUBBLE_CORRECT_EN
  assign q_sel = ones_nx;
`else
  assign q_sel = lead_nx;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bitcnt    <= '0;
      onescnt   <= '0;
      leadcnt   <= '0;
      seen_zero <= 1'b0;
      bubble    <= 1'b0;
      q         <= '0;
      q_valid   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state   <= state_nx;
      q_valid <= last;
      if (state == IDLE && start) begin
        bitcnt    <= '0;
        onescnt   <= '0;
        leadcnt   <= '0;
        seen_zero <= 1'b0;
        bubble    <= 1'b0;
      end else if (take) begin
        bitcnt    <= bitcnt + K'(1);
        onescnt   <= ones_nx;
        leadcnt   <= lead_nx;
        seen_zero <= seen_zero | ~din;
        bubble    <= bubble_nx;
      end
      if (last) begin
        q   <= q_sel;
        err <= bubble_nx;
      end
    end
  end

endmodule

// File: tb/tb_thermometer_serial_decoder.sv
// Directed table-driven bench for thermometer_serial_decoder (default K=7).
module tb_thermometer_serial_decoder;
  localparam int K = 7;
  localparam int W = 2**K-1;

  logic         clk = 1'b0;
  logic         rst, start, din, din_valid;
  logic [K-1:0] q;
  logic         q_valid, busy, err;

  int n_tests = 0;
  int n_fail  = 0;

  thermometer_serial_decoder #(.K(K), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .q(q), .q_valid(q_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] word;
    bit           gaps;    // drop din_valid 3 cycles after every 8th bit, pulse start in the gap
    bit           ovl;     // start together with din_valid=1, din=1
    logic [K-1:0] exp_q;
    logic         exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] therm(input int v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = (i < v);
    return r;
  endfunction

  // Sends one word; all driving and sampling happens on negedges.
  task automatic run_word(input vec_t v, input string tag);
    int  edges;
    bit  early;
    @(negedge clk);
    start = 1'b1;
    din_valid = v.ovl;
    din = v.ovl;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy_after_start"}, busy, 1);
    edges = 0;
    early = 0;
    for (int i = 0; i < W; i++) begin
      if (v.gaps && i > 0 && (i % 8) == 0) begin
        for (int g = 0; g < 3; g++) begin
          din_valid = 1'b0;
          din = 1'b1;
          start = (g == 0);
          @(negedge clk);
          start = 1'b0;
          if (q_valid) early = 1;
        end
      end
      din = v.word[i];
      din_valid = 1'b1;
      @(negedge clk);
      edges++;
      if (q_valid && i != W-1) early = 1;
    end
    din_valid = 1'b0;
    din = 1'b0;
    chk({tag, ".no_early_valid"}, early, 0);
    if (!v.gaps) chk({tag, ".valid_latency"}, q_valid, 1);
    for (int t = 0; t < 4 && !q_valid; t++) @(negedge clk);
    chk({tag, ".q_valid"}, q_valid, 1);
    chk({tag, ".q"}, q, v.exp_q);
    chk({tag, ".err"}, err, v.exp_err);
    chk({tag, ".busy_done"}, busy, 0);
    @(negedge clk);
    chk({tag, ".valid_one_cycle"}, q_valid, 0);
    chk({tag, ".q_hold"}, q, v.exp_q);
  endtask

  initial begin
    vec_t rv;
    rst = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0;
    vecs[0] = '{therm(37),  0, 0, 7'd37,  1'b0};
    vecs[1] = '{therm(0),   0, 0, 7'd0,   1'b0};
    vecs[2] = '{therm(127), 0, 0, 7'd127, 1'b0};
`ifdef THERMO_BUBBLE_CORRECT_EN
    vecs[3] = '{therm(10) | (W'(1) << 11), 0, 0, 7'd11, 1'b1};
`else
    vecs[3] = '{therm(10) | (W'(1) << 11), 0, 0, 7'd10, 1'b1};
`endif
    vecs[4] = '{therm(20),  1, 0, 7'd20,  1'b0};
    vecs[5] = '{therm(3),   0, 1, 7'd3,   1'b0};
    vecs[6] = '{therm(126), 0, 0, 7'd126, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset.q", q, 0);
    chk("reset.q_valid", q_valid, 0);
    chk("reset.busy", busy, 0);
    chk("reset.err", err, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_word(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-word after 50 bits, then a clean value-5 word.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      din = 1'b1; din_valid = 1'b1;
      @(negedge clk);
    end
    chk("midrst.busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0;
    chk("midrst.q", q, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.q_valid", q_valid, 0);
    rv = '{therm(5), 0, 0, 7'd5, 1'b0};
    run_word(rv, "after_rst");

    // A lone din_valid in IDLE (no start) must not start or disturb anything.
    @(negedge clk);
    din = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    chk("idle_din.busy", busy, 0);
    chk("idle_din.q", q, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
